// File: rtl/acc_shift_seq_if.sv
// Instruction handshake plus accumulator control/feedback bundle between the
// upstream decoder, the shift/load sequencer and the accumulator register.
interface acc_shift_seq_if #(
    parameter int N  = 8,
    parameter int CW = 3
);
    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    instr_op;
    logic [CW-1:0] instr_cnt;
    logic [N-1:0]  acc_q;
    logic [1:0]    sh_ctrl;
    logic [CW-1:0] sh_num;
    logic          sh_ls;
    logic          sh_rs;
    logic          sh_clr_n;
    logic          sh_set_n;
    logic          busy;
    logic          done;

    modport master (
        output instr_valid, instr_op, instr_cnt, acc_q,
        input  instr_ready, sh_ctrl, sh_num, sh_ls, sh_rs,
               sh_clr_n, sh_set_n, busy, done
    );

    modport slave (
        input  instr_valid, instr_op, instr_cnt, acc_q,
        output instr_ready, sh_ctrl, sh_num, sh_ls, sh_rs,
               sh_clr_n, sh_set_n, busy, done
    );
endinterface

// File: rtl/acc_shift_seq.sv
// Accumulator shift/load sequencer: turns one decoded instruction into the
// control pins of the 8-bit accumulator, building rotates from 1-bit shifts.
module acc_shift_seq #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input logic           clk,
    input logic           rst,
    acc_shift_seq_if.slave bus
);
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_CLR  = 3'b010;
    localparam logic [2:0] OP_SET  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_ROR  = 3'b111;

    localparam logic [1:0] CTRL_HOLD  = 2'b00;
    localparam logic [1:0] CTRL_LOAD  = 2'b01;
    localparam logic [1:0] CTRL_LEFT  = 2'b10;
    localparam logic [1:0] CTRL_RIGHT = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, ROT, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0]    ctrl_c;
    logic [CW-1:0] num_c;
    logic          ls_c, rs_c, clr_n_c, set_n_c, busy_c, done_c, ready_c;
    logic          unused_acc_mid;

    // Only the edge bits of the feedback word are needed for rotates.
    assign unused_acc_mid = ^bus.acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        ctrl_c  = CTRL_HOLD;
        num_c   = '0;
        ls_c    = 1'b0;
        rs_c    = 1'b0;
        clr_n_c = 1'b1;
        set_n_c = 1'b1;
        busy_c  = 1'b1;
        done_c  = 1'b0;
        ready_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_c  = 1'b0;
                ready_c = 1'b1;
                if (bus.instr_valid) begin
                    op_d  = bus.instr_op;
                    cnt_d = bus.instr_cnt;
                    // Zero-count rotates take the ordinary ISSUE path as a no-op.
                    if ((bus.instr_op == OP_ROL || bus.instr_op == OP_ROR) &&
                        bus.instr_cnt != '0)
                        state_d = ROT;
                    else
                        state_d = ISSUE;
                end
            end

            ISSUE: begin
                case (op_q)
                    OP_LOAD: ctrl_c  = CTRL_LOAD;
                    OP_CLR:  clr_n_c = 1'b0;
                    OP_SET:  set_n_c = 1'b0;
                    OP_SHL: begin
                        if (cnt_q != '0) begin
                            ctrl_c = CTRL_LEFT;
                            num_c  = cnt_q;
                        end
                    end
                    OP_SHR: begin
                        if (cnt_q != '0) begin
                            ctrl_c = CTRL_RIGHT;
                            num_c  = cnt_q;
                        end
                    end
                    default: ;
                endcase
                state_d = DONE;
            end

            ROT: begin
                num_c = CW'(1);
                // Edge bit comes from the live register so each step chains.
                if (op_q == OP_ROL) begin
                    ctrl_c = CTRL_LEFT;
                    ls_c   = bus.acc_q[N-1];
                end else begin
                    ctrl_c = CTRL_RIGHT;
                    rs_c   = bus.acc_q[0];
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = DONE;
            end

            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.instr_ready = ready_c;
    assign bus.sh_ctrl     = ctrl_c;
    assign bus.sh_num      = num_c;
    assign bus.sh_ls       = ls_c;
    assign bus.sh_rs       = rs_c;
    assign bus.sh_clr_n    = clr_n_c;
    assign bus.sh_set_n    = set_n_c;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
endmodule

// File: tb/tb_acc_shift_seq.sv
// Bench for acc_shift_seq with a behavioural accumulator register closing the
// acc_q loop; completions are checked by a done-driven scoreboard monitor.
module tb_acc_shift_seq;
    localparam int N  = 8;
    localparam int CW = 3;
    localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, CLR = 3'd2, SET = 3'd3;
    localparam logic [2:0] SHL = 3'd4, SHR = 3'd5, ROL = 3'd6, ROR = 3'd7;
    localparam logic [11:0] RST_OUTS = 12'b00_000_0_0_1_1_0_0_1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    acc_shift_seq_if #(.N(N), .CW(CW)) bus ();
    acc_shift_seq #(.N(N), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] acc;
        int           cyc;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int n_ctrl   = 0;
    int n_set_lo = 0;
    int n_clr_lo = 0;

    logic [N-1:0] acc_r   = '0;
    logic [N-1:0] ld_data = '0;
    assign bus.acc_q = acc_r;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic logic [11:0] outs();
        return {bus.sh_ctrl, bus.sh_num, bus.sh_ls, bus.sh_rs, bus.sh_clr_n,
                bus.sh_set_n, bus.busy, bus.done, bus.instr_ready};
    endfunction

    function automatic logic [N-1:0] shl_f(logic [N-1:0] v, logic [CW-1:0] k, logic fill);
        for (int i = 0; i < int'(k); i++) v = {v[N-2:0], fill};
        return v;
    endfunction

    function automatic logic [N-1:0] shr_f(logic [N-1:0] v, logic [CW-1:0] k, logic fill);
        for (int i = 0; i < int'(k); i++) v = {fill, v[N-1:1]};
        return v;
    endfunction

    // Accumulator register model; unaffected by the sequencer reset.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.instr_valid && bus.instr_ready) n_acc <= n_acc + 1;
        if (!bus.sh_clr_n)      acc_r <= '0;
        else if (!bus.sh_set_n) acc_r <= '1;
        else begin
            case (bus.sh_ctrl)
                2'b01:   acc_r <= ld_data;
                2'b10:   acc_r <= shl_f(acc_r, bus.sh_num, bus.sh_ls);
                2'b11:   acc_r <= shr_f(acc_r, bus.sh_num, bus.sh_rs);
                default: ;
            endcase
        end
    end

    // Scoreboard monitor and per-cycle invariants.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_is_not_busy", {31'd0, bus.instr_ready}, {31'd0, !bus.busy});
            chk("clr_set_not_both_low", {31'd0, bus.sh_clr_n | bus.sh_set_n}, 32'd1);
            if (!bus.sh_set_n) n_set_lo++;
            if (!bus.sh_clr_n) n_clr_lo++;
            if (bus.sh_ctrl != 2'b00) n_ctrl++;
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", {31'd0, bus.done}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("done_acc", {24'd0, bus.acc_q}, {24'd0, e.acc});
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        @(negedge clk);
        while (!bus.instr_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", {31'd0, bus.instr_ready}, 32'd1);
    endtask

    // Returns 1 time unit after the accept edge.
    task automatic send(input logic [2:0] op, input logic [CW-1:0] cnt,
                        input logic [N-1:0] ld, input logic [N-1:0] exp_acc,
                        input int lat, input bit push);
        exp_t e;
        wait_ready();
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_cnt   = cnt;
        ld_data         = ld;
        e.acc = exp_acc;
        e.cyc = cyc + lat;
        if (push) sb_q.push_back(e);
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
    endtask

    task automatic rot_step(input bit left, input logic edge_bit, input logic [N-1:0] acc_now);
        @(negedge clk);
        chk("rot_ctrl", {30'd0, bus.sh_ctrl}, left ? 32'd2 : 32'd3);
        chk("rot_num", {29'd0, bus.sh_num}, 32'd1);
        chk(left ? "rot_ls" : "rot_rs", {31'd0, left ? bus.sh_ls : bus.sh_rs}, {31'd0, edge_bit});
        chk("rot_acc_before_step", {24'd0, bus.acc_q}, {24'd0, acc_now});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_base, ctrl_base, k0;
        bus.instr_valid = 1'b0;
        bus.instr_op    = NOP;
        bus.instr_cnt   = '0;
        #2 chk("reset_outputs", {20'd0, outs()}, {20'd0, RST_OUTS});
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ROL 3 from 0x96: 0x2D, 0x5A, 0xB4.
        send(LOAD, 0, 8'h96, 8'h96, 2, 1);
        send(ROL, 3, 8'h00, 8'hB4, 4, 1);
        rot_step(1, 1'b1, 8'h96);
        rot_step(1, 1'b0, 8'h2D);
        rot_step(1, 1'b0, 8'h5A);

        // ROR 2 from 0x96: 0x4B, 0xA5.
        send(LOAD, 0, 8'h96, 8'h96, 2, 1);
        send(ROR, 2, 8'h00, 8'hA5, 3, 1);
        rot_step(0, 1'b0, 8'h96);
        rot_step(0, 1'b1, 8'h4B);

        // SHL 3 then SHR 0.
        send(LOAD, 0, 8'h96, 8'h96, 2, 1);
        send(SHL, 3, 8'h00, 8'hB0, 2, 1);
        @(negedge clk);
        chk("shl_issue", {20'd0, outs()}, {20'd0, 12'b10_011_0_0_1_1_1_0_0});
        send(SHR, 0, 8'h00, 8'hB0, 2, 1);
        @(negedge clk);
        chk("shr0_issue", {20'd0, outs()}, {20'd0, 12'b00_000_0_0_1_1_1_0_0});

        // LOAD, SET, CLR.
        send(LOAD, 0, 8'h3C, 8'h3C, 2, 1);
        @(negedge clk);
        chk("load_issue", {20'd0, outs()}, {20'd0, 12'b01_000_0_0_1_1_1_0_0});
        @(negedge clk);
        chk("done_ready_low", {31'd0, bus.instr_ready}, 32'd0);
        send(SET, 0, 8'h00, 8'hFF, 2, 1);
        @(negedge clk);
        chk("set_issue", {20'd0, outs()}, {20'd0, 12'b00_000_0_0_1_0_1_0_0});
        send(CLR, 0, 8'h00, 8'h00, 2, 1);
        @(negedge clk);
        chk("clr_issue", {20'd0, outs()}, {20'd0, 12'b00_000_0_0_0_1_1_0_0});

        // instr_valid held high across three IDLE visits.
        send(LOAD, 0, 8'h01, 8'h01, 2, 1);
        wait_ready();
        acc_base  = n_acc;
        ctrl_base = n_ctrl;
        k0        = cyc;
        bus.instr_valid = 1'b1;
        bus.instr_op    = SHL;
        bus.instr_cnt   = 3'd1;
        sb_q.push_back('{8'h02, k0 + 2});
        sb_q.push_back('{8'h04, k0 + 5});
        sb_q.push_back('{8'h08, k0 + 8});
        repeat (7) @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        wait_ready();
        chk("hold_accepts", n_acc - acc_base, 32'd3);
        chk("hold_issued_ops", n_ctrl - ctrl_base, 32'd3);

        // Reset during the 2nd ROT cycle of ROL 5.
        send(LOAD, 0, 8'h96, 8'h96, 2, 1);
        send(ROL, 5, 8'h00, 8'h00, 6, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rot2_acc", {24'd0, bus.acc_q}, {24'd0, 8'h2D});
        rst = 1'b1;
        #1 chk("async_reset_outputs", {20'd0, outs()}, {20'd0, RST_OUTS});
        repeat (3) @(negedge clk);
        chk("acc_kept_in_reset", {24'd0, bus.acc_q}, {24'd0, 8'h2D});
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("acc_kept_after_reset", {24'd0, bus.acc_q}, {24'd0, 8'h2D});
        chk("idle_after_reset", {20'd0, outs()}, {20'd0, RST_OUTS});

        chk("scoreboard_drained", sb_q.size(), 32'd0);
        chk("set_low_cycles", n_set_lo, 32'd1);
        chk("clr_low_cycles", n_clr_lo, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
